// File: rtl/cpu_boot_loader.sv
// cpu_boot_loader
// Host-side loader for the pipelined RISC-V core. It receives a framed byte
// stream over a valid/ready interface and does three things:
//   - preloads instruction memory (32-bit words) through the addr_ext/wen_ext/wdata_ext port
//   - preloads data memory (64-bit words) through the addr_ext_2/wen_ext_2/wdata_ext_2 port
//   - starts and stops the core through cpu_enable
//
// Ports
//   clk          : only clock
//   arst_n       : synchronous reset, active-high despite the name
//   rx_valid     : rx_data carries a byte
//   rx_data      : command / payload byte
//   rx_ready     : byte is accepted when rx_valid & rx_ready
//   cpu_enable   : core enable
//   addr_ext     : IMEM byte address
//   wen_ext      : IMEM write enable
//   ren_ext      : IMEM read enable (tied 0)
//   wdata_ext    : IMEM write word
//   addr_ext_2   : DMEM byte address
//   wen_ext_2    : DMEM write enable
//   ren_ext_2    : DMEM read enable (tied 0)
//   wdata_ext_2  : DMEM write word
//   busy         : FSM is not idle
//   error        : sticky protocol error, cleared only by reset
//
// Frame: CMD, BASE lo/hi, COUNT lo/hi, then COUNT little-endian payload words.
//   CMD 0x01 = IMEM load
//   CMD 0x02 = DMEM load
//   CMD 0x03 = RUN
//   CMD 0x04 = HALT
module cpu_boot_loader #(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        cpu_enable,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    output logic        busy,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        BASE_LO,
        BASE_HI,
        CNT_LO,
        CNT_HI,
        DATA,
        WRITE
    } state_t;

    localparam logic [16:0] IMEM_LIMIT = 17'(IMEM_WORDS);
    localparam logic [16:0] DMEM_LIMIT = 17'(DMEM_WORDS);

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic        is_dmem;
    logic [15:0] base;
    logic [15:0] count;
    logic [15:0] word_idx;
    logic [2:0]  byte_cnt;
    logic [2:0]  last_byte;
    logic [63:0] word_buf;
    logic [63:0] next_buf;
    logic [15:0] full_count;
    logic [16:0] frame_end;
    logic [16:0] frame_limit;
    logic [16:0] cur_index;
    logic        last_word;
    logic        set_error;
    logic        set_run;
    logic        set_halt;
    logic        start_load;

    assign accept      = rx_valid && rx_ready;
    assign last_byte   = is_dmem ? 3'd7 : 3'd3;
    // COUNT high byte is still on rx_data when CNT_HI decides where to go.
    assign full_count  = {rx_data, count[7:0]};
    // 17-bit sum so BASE+COUNT cannot wrap past the bounds check.
    assign frame_end   = {1'b0, base} + {1'b0, full_count};
    assign frame_limit = is_dmem ? DMEM_LIMIT : IMEM_LIMIT;
    assign cur_index   = {1'b0, base} + {1'b0, word_idx};
    assign last_word   = ({1'b0, word_idx} + 17'd1) == {1'b0, count};

    // Insert the incoming byte at its little-endian lane of the word being built.
    always_comb begin
        next_buf = word_buf;
        next_buf[{byte_cnt, 3'b000} +: 8] = rx_data;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (arst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the one-shot command decode flags.
    always_comb begin
        next_state = state;
        set_error  = 1'b0;
        set_run    = 1'b0;
        set_halt   = 1'b0;
        start_load = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (rx_data)
                        8'h01, 8'h02: begin
                            // Loading into a running core is refused outright.
                            if (cpu_enable) begin
                                set_error = 1'b1;
                            end else begin
                                start_load = 1'b1;
                                next_state = BASE_LO;
                            end
                        end
                        8'h03:   set_run   = 1'b1;
                        8'h04:   set_halt  = 1'b1;
                        default: set_error = 1'b1;
                    endcase
                end
            end
            BASE_LO: if (accept) next_state = BASE_HI;
            BASE_HI: if (accept) next_state = CNT_LO;
            CNT_LO:  if (accept) next_state = CNT_HI;
            CNT_HI: begin
                if (accept) begin
                    if (full_count == 16'd0) begin
                        next_state = IDLE;
                    end else if (frame_end > frame_limit) begin
                        set_error  = 1'b1;
                        next_state = IDLE;
                    end else begin
                        next_state = DATA;
                    end
                end
            end
            DATA: if (accept && byte_cnt == last_byte) next_state = WRITE;
            WRITE: next_state = last_word ? IDLE : DATA;
            default: next_state = IDLE;
        endcase
    end

    // Output decode; everything is forced quiet while reset is held.
    always_comb begin
        rx_ready  = !arst_n && (state != WRITE);
        busy      = !arst_n && (state != IDLE);
        wen_ext   = !arst_n && (state == WRITE) && !is_dmem;
        wen_ext_2 = !arst_n && (state == WRITE) && is_dmem;
        ren_ext   = 1'b0;
        ren_ext_2 = 1'b0;
    end

    // Frame datapath. The address/data ports are loaded together with the
    // final payload byte, so they are valid during WRITE and hold afterwards.
    always_ff @(posedge clk) begin
        if (arst_n) begin
            cpu_enable  <= 1'b0;
            error       <= 1'b0;
            is_dmem     <= 1'b0;
            base        <= '0;
            count       <= '0;
            word_idx    <= '0;
            byte_cnt    <= '0;
            word_buf    <= '0;
            addr_ext    <= '0;
            wdata_ext   <= '0;
            addr_ext_2  <= '0;
            wdata_ext_2 <= '0;
        end else begin
            if (set_error)  error      <= 1'b1;
            if (set_run)    cpu_enable <= 1'b1;
            if (set_halt)   cpu_enable <= 1'b0;
            if (start_load) is_dmem    <= (rx_data == 8'h02);

            case (state)
                BASE_LO: if (accept) base[7:0]   <= rx_data;
                BASE_HI: if (accept) base[15:8]  <= rx_data;
                CNT_LO:  if (accept) count[7:0]  <= rx_data;
                CNT_HI: begin
                    if (accept) begin
                        count[15:8] <= rx_data;
                        word_idx    <= '0;
                        byte_cnt    <= '0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        word_buf <= next_buf;
                        if (byte_cnt == last_byte) begin
                            byte_cnt <= '0;
                            if (is_dmem) begin
                                addr_ext_2  <= {44'd0, cur_index, 3'b000};
                                wdata_ext_2 <= next_buf;
                            end else begin
                                addr_ext    <= {45'd0, cur_index, 2'b00};
                                wdata_ext   <= next_buf[31:0];
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                end
                WRITE: word_idx <= word_idx + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Directed self-checking bench for cpu_boot_loader. Inputs change on the
// falling edge, outputs are sampled on the falling edge, and a monitor logs
// every write-enable cycle so pulse counts and contents can be checked.
module tb_cpu_boot_loader;

    logic        clk;
    logic        arst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        cpu_enable;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic        busy;
    logic        error;

    int checks = 0;
    int errors = 0;

    int          imem_writes;
    int          dmem_writes;
    logic [63:0] imem_addr_log [4];
    logic [31:0] imem_data_log [4];
    logic [63:0] dmem_addr_log [4];
    logic [63:0] dmem_data_log [4];

    cpu_boot_loader #(.IMEM_WORDS(512), .DMEM_WORDS(1024)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .cpu_enable  (cpu_enable),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .busy        (busy),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each write cycle is logged once per falling edge, so a stretched
    // pulse shows up as an extra write.
    always @(negedge clk) begin
        if (wen_ext === 1'b1) begin
            if (imem_writes < 4) begin
                imem_addr_log[imem_writes] = addr_ext;
                imem_data_log[imem_writes] = wdata_ext;
            end
            imem_writes++;
        end
        if (wen_ext_2 === 1'b1) begin
            if (dmem_writes < 4) begin
                dmem_addr_log[dmem_writes] = addr_ext_2;
                dmem_data_log[dmem_writes] = wdata_ext_2;
            end
            dmem_writes++;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clear_log();
        imem_writes = 0;
        dmem_writes = 0;
        for (int i = 0; i < 4; i++) begin
            imem_addr_log[i] = '0;
            imem_data_log[i] = '0;
            dmem_addr_log[i] = '0;
            dmem_data_log[i] = '0;
        end
    endtask

    // Called and returns on a falling edge; optional random idle gap first.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int  gap;
        int  guard;
        bit  done;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        done  = 1'b0;
        guard = 0;
        while (!done && guard < 50) begin
            if (rx_ready === 1'b1) done = 1'b1;
            @(negedge clk);
            guard++;
        end
        rx_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_timeout: byte %02h never accepted, expected rx_ready=1", b);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst_n   = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        arst_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        arst_n   = 1'b1;
        clear_log();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (cpu_enable !== 1'b0) begin errors++; $display("[TB] FAIL rst_cpu_enable: got %b expected 0", cpu_enable); end
        checks++; if (wen_ext !== 1'b0) begin errors++; $display("[TB] FAIL rst_wen_ext: got %b expected 0", wen_ext); end
        checks++; if (wen_ext_2 !== 1'b0) begin errors++; $display("[TB] FAIL rst_wen_ext_2: got %b expected 0", wen_ext_2); end
        checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL rst_error: got %b expected 0", error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (addr_ext !== 64'd0) begin errors++; $display("[TB] FAIL rst_addr_ext: got %0h expected 0", addr_ext); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_rx_ready: got %b expected 0", rx_ready); end
        checks++; if (ren_ext !== 1'b0 || ren_ext_2 !== 1'b0) begin errors++; $display("[TB] FAIL rst_ren: got %b/%b expected 0/0", ren_ext, ren_ext_2); end
        arst_n = 1'b0;
        @(negedge clk);
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_rx_ready: got %b expected 1", rx_ready); end
    endtask

    task automatic test_imem_load();
        logic [7:0] bytes [13];
        bytes = '{8'h01, 8'h02, 8'h00, 8'h02, 8'h00,
                  8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        clear_log();
        for (int i = 0; i < 13; i++) send_byte(bytes[i], 0);
        repeat (3) @(negedge clk);
        checks++; if (imem_writes !== 2) begin errors++; $display("[TB] FAIL imem_count: got %0d expected 2", imem_writes); end
        checks++; if (imem_addr_log[0] !== 64'd8) begin errors++; $display("[TB] FAIL imem_addr0: got %0h expected 8", imem_addr_log[0]); end
        checks++; if (imem_data_log[0] !== 32'h00000013) begin errors++; $display("[TB] FAIL imem_data0: got %08h expected 00000013", imem_data_log[0]); end
        checks++; if (imem_addr_log[1] !== 64'd12) begin errors++; $display("[TB] FAIL imem_addr1: got %0h expected c", imem_addr_log[1]); end
        checks++; if (imem_data_log[1] !== 32'h00100093) begin errors++; $display("[TB] FAIL imem_data1: got %08h expected 00100093", imem_data_log[1]); end
        checks++; if (dmem_writes !== 0) begin errors++; $display("[TB] FAIL imem_no_dmem: got %0d expected 0", dmem_writes); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL imem_busy: got %b expected 0", busy); end
        checks++; if (addr_ext !== 64'd12) begin errors++; $display("[TB] FAIL imem_addr_hold: got %0h expected c", addr_ext); end
    endtask

    task automatic test_dmem_load();
        logic [7:0] bytes [13];
        bytes = '{8'h02, 8'h03, 8'h00, 8'h01, 8'h00,
                  8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        clear_log();
        for (int i = 0; i < 13; i++) send_byte(bytes[i], 0);
        repeat (3) @(negedge clk);
        checks++; if (dmem_writes !== 1) begin errors++; $display("[TB] FAIL dmem_count: got %0d expected 1", dmem_writes); end
        checks++; if (dmem_addr_log[0] !== 64'd24) begin errors++; $display("[TB] FAIL dmem_addr: got %0h expected 18", dmem_addr_log[0]); end
        checks++; if (dmem_data_log[0] !== 64'h0807060504030201) begin errors++; $display("[TB] FAIL dmem_data: got %016h expected 0807060504030201", dmem_data_log[0]); end
        checks++; if (imem_writes !== 0) begin errors++; $display("[TB] FAIL dmem_no_imem: got %0d expected 0", imem_writes); end
        checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL dmem_error: got %b expected 0", error); end
    endtask

    task automatic test_run_halt();
        logic [7:0] bytes [5];
        bytes = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00};
        clear_log();
        checks++; if (cpu_enable !== 1'b0) begin errors++; $display("[TB] FAIL run_pre: got %b expected 0", cpu_enable); end
        send_byte(8'h03, 0);
        checks++; if (cpu_enable !== 1'b1) begin errors++; $display("[TB] FAIL run_enable: got %b expected 1", cpu_enable); end
        for (int i = 0; i < 5; i++) send_byte(bytes[i], 0);
        repeat (2) @(negedge clk);
        checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL run_load_error: got %b expected 1", error); end
        checks++; if (imem_writes !== 0 || dmem_writes !== 0) begin errors++; $display("[TB] FAIL run_no_write: got %0d/%0d expected 0/0", imem_writes, dmem_writes); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL run_busy: got %b expected 0", busy); end
        checks++; if (cpu_enable !== 1'b1) begin errors++; $display("[TB] FAIL run_still_enabled: got %b expected 1", cpu_enable); end
        send_byte(8'h04, 0);
        checks++; if (cpu_enable !== 1'b0) begin errors++; $display("[TB] FAIL halt_enable: got %b expected 0", cpu_enable); end
        checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL error_sticky: got %b expected 1", error); end
    endtask

    task automatic test_bounds();
        logic [7:0] over   [5];
        logic [7:0] edge_b [9];
        logic [7:0] zero   [5];
        logic [7:0] dover  [5];
        over   = '{8'h01, 8'hFF, 8'h01, 8'h02, 8'h00};
        edge_b = '{8'h01, 8'hFF, 8'h01, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        zero   = '{8'h02, 8'h05, 8'h00, 8'h00, 8'h00};
        dover  = '{8'h02, 8'hFF, 8'h03, 8'h02, 8'h00};

        do_reset();
        clear_log();
        for (int i = 0; i < 5; i++) send_byte(over[i], 0);
        repeat (2) @(negedge clk);
        checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL bound_imem_error: got %b expected 1", error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL bound_imem_idle: got busy %b expected 0", busy); end
        checks++; if (imem_writes !== 0) begin errors++; $display("[TB] FAIL bound_imem_nowrite: got %0d expected 0", imem_writes); end

        do_reset();
        clear_log();
        for (int i = 0; i < 9; i++) send_byte(edge_b[i], 0);
        repeat (3) @(negedge clk);
        checks++; if (imem_writes !== 1) begin errors++; $display("[TB] FAIL edge_count: got %0d expected 1", imem_writes); end
        checks++; if (imem_addr_log[0] !== 64'd2044) begin errors++; $display("[TB] FAIL edge_addr: got %0h expected 7fc", imem_addr_log[0]); end
        checks++; if (imem_data_log[0] !== 32'hDDCCBBAA) begin errors++; $display("[TB] FAIL edge_data: got %08h expected ddccbbaa", imem_data_log[0]); end
        checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL edge_error: got %b expected 0", error); end

        clear_log();
        for (int i = 0; i < 5; i++) send_byte(zero[i], 0);
        repeat (2) @(negedge clk);
        checks++; if (imem_writes !== 0 || dmem_writes !== 0) begin errors++; $display("[TB] FAIL zero_nowrite: got %0d/%0d expected 0/0", imem_writes, dmem_writes); end
        checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL zero_error: got %b expected 0", error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy: got %b expected 0", busy); end

        for (int i = 0; i < 5; i++) send_byte(dover[i], 0);
        repeat (2) @(negedge clk);
        checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL bound_dmem_error: got %b expected 1", error); end
        checks++; if (dmem_writes !== 0) begin errors++; $display("[TB] FAIL bound_dmem_nowrite: got %0d expected 0", dmem_writes); end
    endtask

    task automatic test_reset_midload();
        logic [7:0] hdr   [5];
        logic [7:0] clean [9];
        hdr   = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00};
        clean = '{8'h01, 8'h04, 8'h00, 8'h01, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        clear_log();
        for (int i = 0; i < 5; i++) send_byte(hdr[i], 2);
        send_byte(8'h11, 2);
        send_byte(8'h22, 2);
        arst_n = 1'b1;
        @(negedge clk);
        checks++; if (wen_ext !== 1'b0 || wen_ext_2 !== 1'b0) begin errors++; $display("[TB] FAIL mid_wen: got %b/%b expected 0/0", wen_ext, wen_ext_2); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL mid_error: got %b expected 0", error); end
        checks++; if (cpu_enable !== 1'b0) begin errors++; $display("[TB] FAIL mid_cpu_enable: got %b expected 0", cpu_enable); end
        checks++; if (addr_ext !== 64'd0 || wdata_ext !== 32'd0) begin errors++; $display("[TB] FAIL mid_imem_port: got %0h/%0h expected 0/0", addr_ext, wdata_ext); end
        checks++; if (addr_ext_2 !== 64'd0 || wdata_ext_2 !== 64'd0) begin errors++; $display("[TB] FAIL mid_dmem_port: got %0h/%0h expected 0/0", addr_ext_2, wdata_ext_2); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_rx_ready: got %b expected 0", rx_ready); end
        @(negedge clk);
        arst_n = 1'b0;
        @(negedge clk);
        checks++; if (imem_writes !== 0) begin errors++; $display("[TB] FAIL mid_nowrite: got %0d expected 0", imem_writes); end
        for (int i = 0; i < 9; i++) send_byte(clean[i], 2);
        repeat (3) @(negedge clk);
        checks++; if (imem_writes !== 1) begin errors++; $display("[TB] FAIL clean_count: got %0d expected 1", imem_writes); end
        checks++; if (imem_addr_log[0] !== 64'd16) begin errors++; $display("[TB] FAIL clean_addr: got %0h expected 10", imem_addr_log[0]); end
        checks++; if (imem_data_log[0] !== 32'hD4C3B2A1) begin errors++; $display("[TB] FAIL clean_data: got %08h expected d4c3b2a1", imem_data_log[0]); end
        checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL clean_error: got %b expected 0", error); end
    endtask

    initial begin
        test_reset();
        test_imem_load();
        test_dmem_load();
        test_run_halt();
        test_bounds();
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
